// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared state encoding and parameter defaults for the front panel
package panel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } panel_state_e;

  localparam int TICK_DIV_DEF = 256;
  localparam int FILT_LEN_DEF = 3;
  localparam int RUN_DIV_DEF  = 8;

endpackage

// File: rtl/btn_step_ctrl_if.sv
// rtl/btn_step_ctrl_if.sv - button inputs and step/status outputs of the panel controller
interface btn_step_ctrl_if;

  logic        btn_step;
  logic        btn_run;
  logic        halt_req;
  logic        cpu_step;
  logic        run_mode;
  logic        halted;
  logic [15:0] step_cnt;
  logic        sample_tick;

  // board / CPU side: drives buttons and halt, observes strobes
  modport master (
    output btn_step, btn_run, halt_req,
    input  cpu_step, run_mode, halted, step_cnt, sample_tick
  );

  // controller side
  modport slave (
    input  btn_step, btn_run, halt_req,
    output cpu_step, run_mode, halted, step_cnt, sample_tick
  );

endinterface

// File: rtl/btn_filter.sv
// rtl/btn_filter.sv - button synchroniser, tick-gated level filter and press pulse
module btn_filter
  import panel_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int                CW       = $clog2(FILT_LEN);
  localparam logic [CW-1:0]     CNT_LAST = CW'(FILT_LEN - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_level_d;
  logic          r_armed;
  logic [CW-1:0] r_cnt;

  // two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
    end
  end

  // accept a new level only after FILT_LEN consecutive differing samples;
  // a press is armed only once the button has been seen released after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_level_d <= r_level;
      if (tick) begin
        if (!r_s2 && !r_level) begin
          r_armed <= 1'b1;
        end
        if (r_s2 != r_level) begin
          if (r_cnt == CNT_LAST) begin
            r_level <= r_s2;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign level = r_level;
  assign press = r_level & ~r_level_d & r_armed;

endmodule

// File: rtl/btn_step_ctrl.sv
// rtl/btn_step_ctrl.sv - front-panel step/run controller producing CPU step strobes
module btn_step_ctrl
  import panel_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int FILT_LEN = FILT_LEN_DEF,
  parameter int RUN_DIV  = RUN_DIV_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  btn_step_ctrl_if.slave bus
);

  localparam int              TC_W      = $clog2(TICK_DIV);
  localparam int              RC_W      = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [TC_W-1:0] TICK_LAST = TC_W'(TICK_DIV - 1);
  localparam logic [RC_W-1:0] RUN_LAST  = RC_W'(RUN_DIV - 1);

  logic [TC_W-1:0] r_tick_cnt;
  logic [RC_W-1:0] r_run_cnt;
  panel_state_e    r_state;
  logic            r_cpu_step;
  logic            r_run_mode;
  logic            r_halted;
  logic [15:0]     r_step_cnt;

  logic            w_tick;
  logic            w_step_press;
  logic            w_run_press;
  logic            w_unused_step_level;
  logic            w_unused_run_level;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // free-running sample tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TC_W'(1);
    end
  end

  btn_filter #(.FILT_LEN(FILT_LEN)) u_step_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick),
    .raw   (bus.btn_step),
    .level (w_unused_step_level),
    .press (w_step_press)
  );

  btn_filter #(.FILT_LEN(FILT_LEN)) u_run_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick),
    .raw   (bus.btn_run),
    .level (w_unused_run_level),
    .press (w_run_press)
  );

  // mode machine; halt beats run press, run press beats any step in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_run_cnt  <= '0;
      r_cpu_step <= 1'b0;
      r_run_mode <= 1'b0;
      r_halted   <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_cpu_step <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.halt_req) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_run_press) begin
            r_state    <= ST_RUN;
            r_run_mode <= 1'b1;
            r_run_cnt  <= '0;
          end else if (w_step_press) begin
            r_cpu_step <= 1'b1;
            r_step_cnt <= r_step_cnt + 16'd1;
          end
        end
        ST_RUN: begin
          if (bus.halt_req) begin
            r_state    <= ST_HALT;
            r_run_mode <= 1'b0;
            r_halted   <= 1'b1;
          end else if (w_run_press) begin
            r_state    <= ST_IDLE;
            r_run_mode <= 1'b0;
          end else if (w_tick) begin
            if (r_run_cnt == RUN_LAST) begin
              r_run_cnt  <= '0;
              r_cpu_step <= 1'b1;
              r_step_cnt <= r_step_cnt + 16'd1;
            end else begin
              r_run_cnt <= r_run_cnt + RC_W'(1);
            end
          end
        end
        ST_HALT: begin
          if (w_run_press && !bus.halt_req) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_run_mode <= 1'b0;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_step    = r_cpu_step;
  assign bus.run_mode    = r_run_mode;
  assign bus.halted      = r_halted;
  assign bus.step_cnt    = r_step_cnt;
  assign bus.sample_tick = w_tick;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// tb/tb_btn_step_ctrl.sv - randomized self-checking bench for btn_step_ctrl
module tb_btn_step_ctrl;

  localparam int TICK_DIV = 4;
  localparam int FILT_LEN = 3;
  localparam int RUN_DIV  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_err   = 0;
  int   n_chk   = 0;
  int   n_pulse = 0;

  btn_step_ctrl_if bus();

  btn_step_ctrl #(
    .TICK_DIV (TICK_DIV),
    .FILT_LEN (FILT_LEN),
    .RUN_DIV  (RUN_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_HALT} mode_e;
  mode_e             m_mode;
  int                m_edges;
  int                m_run_ticks;
  logic [15:0]       m_step_cnt;
  bit                m_cpu_step;
  bit                m_h0 [2];
  bit                m_h1 [2];
  bit                m_lvl [2];
  bit                m_arm [2];
  bit                m_press [2];
  bit                m_raw [2];
  logic [FILT_LEN-1:0] m_win [2];
  int                m_seen [2];
  bit                m_tick;
  bit                m_fire;
  bit                m_samp;
  bit                m_rose;
  bit                m_same;

  // behavioural model: edges counted since reset, sample windows, mode rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode      = M_IDLE;
      m_edges     = 0;
      m_run_ticks = 0;
      m_step_cnt  = 16'd0;
      m_cpu_step  = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_h0[b] = 0; m_h1[b] = 0; m_lvl[b] = 0; m_arm[b] = 0;
        m_press[b] = 0; m_win[b] = '0; m_seen[b] = 0;
      end
    end else begin
      m_tick = ((m_edges % TICK_DIV) == TICK_DIV - 1);
      m_fire = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (bus.halt_req) m_mode = M_HALT;
          else if (m_press[1]) begin m_mode = M_RUN; m_run_ticks = 0; end
          else if (m_press[0]) m_fire = 1'b1;
        end
        M_RUN: begin
          if (bus.halt_req) m_mode = M_HALT;
          else if (m_press[1]) m_mode = M_IDLE;
          else if (m_tick) begin
            m_run_ticks++;
            if ((m_run_ticks % RUN_DIV) == 0) m_fire = 1'b1;
          end
        end
        default: begin
          if (m_press[1] && !bus.halt_req) m_mode = M_IDLE;
        end
      endcase
      m_cpu_step = m_fire;
      if (m_fire) m_step_cnt = m_step_cnt + 16'd1;
      m_raw[0] = bus.btn_step;
      m_raw[1] = bus.btn_run;
      for (int b = 0; b < 2; b++) begin
        m_samp = m_h1[b];
        m_rose = 1'b0;
        if (m_tick) begin
          if (!m_samp && !m_lvl[b]) m_arm[b] = 1'b1;
          m_win[b] = {m_win[b][FILT_LEN-2:0], m_samp};
          if (m_seen[b] < FILT_LEN) m_seen[b]++;
          m_same = m_samp ? (m_win[b] == '1) : (m_win[b] == '0);
          if (m_seen[b] >= FILT_LEN && m_same && m_samp != m_lvl[b]) begin
            m_lvl[b] = m_samp;
            m_rose   = m_samp;
          end
        end
        m_press[b] = m_rose && m_arm[b];
        m_h1[b] = m_h0[b];
        m_h0[b] = m_raw[b];
      end
      m_edges++;
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("cpu_step",    bus.cpu_step,    m_cpu_step);
    chk("run_mode",    bus.run_mode,    m_mode == M_RUN);
    chk("halted",      bus.halted,      m_mode == M_HALT);
    chk("step_cnt",    bus.step_cnt,    m_step_cnt);
    chk("sample_tick", bus.sample_tick, (m_edges % TICK_DIV) == TICK_DIV - 1);
    if (bus.cpu_step) n_pulse++;
  end

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    bit found;
    bus.btn_step = 1'b0;
    bus.btn_run  = 1'b0;
    bus.halt_req = 1'b0;

    // reset state and tick phase
    cyc(3);
    chk("rst_cpu_step", bus.cpu_step, 0);
    chk("rst_run_mode", bus.run_mode, 0);
    chk("rst_halted",   bus.halted,   0);
    chk("rst_step_cnt", bus.step_cnt, 0);
    chk("rst_tick",     bus.sample_tick, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("tick_phase", bus.sample_tick, (i % TICK_DIV) == 3);
    end
    cyc(88);
    chk("idle_step_cnt", bus.step_cnt, 0);
    chk("idle_pulses", n_pulse, 0);

    // manual steps
    bus.btn_step = 1'b1; cyc(20); bus.btn_step = 1'b0; cyc(20);
    chk("step_first", bus.step_cnt, 1);
    chk("step_first_pulses", n_pulse, 1);
    bus.btn_step = 1'b1; cyc(20); bus.btn_step = 1'b0; cyc(20);
    chk("step_second", bus.step_cnt, 2);

    // short glitch rejected
    bus.btn_step = 1'b1; cyc(6); bus.btn_step = 1'b0; cyc(24);
    chk("glitch_step_cnt", bus.step_cnt, 2);

    // free run, step ignored, stop
    bus.btn_run = 1'b1; cyc(20); bus.btn_run = 1'b0; cyc(20);
    chk("run_entered", bus.run_mode, 1);
    p0 = n_pulse; cyc(32);
    chk("run_rate", n_pulse - p0, 4);
    p0 = n_pulse;
    bus.btn_step = 1'b1; cyc(16); bus.btn_step = 1'b0; cyc(16);
    chk("run_step_ignored", n_pulse - p0, 4);
    bus.btn_run = 1'b1; cyc(20); bus.btn_run = 1'b0; cyc(20);
    chk("run_stopped", bus.run_mode, 0);
    p0 = n_pulse; cyc(32);
    chk("stopped_pulses", n_pulse - p0, 0);

    // halt coincident with a run press while running
    bus.btn_run = 1'b1; cyc(20); bus.btn_run = 1'b0; cyc(20);
    bus.btn_run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (m_press[1]) found = 1'b1;
    end
    chk("halt_press_seen", found, 1);
    bus.halt_req = 1'b1;
    cyc(3);
    chk("halt_entered", bus.halted, 1);
    chk("halt_run_mode", bus.run_mode, 0);
    bus.btn_run = 1'b0; cyc(20);
    bus.halt_req = 1'b0;
    p0 = n_pulse; cyc(10);
    chk("halt_sticky", bus.halted, 1);
    chk("halt_no_steps", n_pulse - p0, 0);
    bus.btn_run = 1'b1; cyc(20); bus.btn_run = 1'b0; cyc(20);
    chk("halt_left", bus.halted, 0);
    chk("halt_left_idle", bus.run_mode, 0);

    // step counter wrap
    @(negedge clk); #2;
    force dut.r_step_cnt = 16'hffff;
    m_step_cnt = 16'hffff;
    @(negedge clk); #2;
    release dut.r_step_cnt;
    cyc(2);
    chk("preload", bus.step_cnt, 16'hffff);
    bus.btn_step = 1'b1; cyc(20); bus.btn_step = 1'b0; cyc(20);
    chk("wrap", bus.step_cnt, 0);

    // button held through reset must be released before it steps
    bus.btn_step = 1'b1; cyc(20);
    @(negedge clk); #2; rst_n = 1'b0;
    cyc(2); rst_n = 1'b1;
    p0 = n_pulse; cyc(40);
    chk("held_no_press", n_pulse - p0, 0);
    bus.btn_step = 1'b0; cyc(20);
    bus.btn_step = 1'b1; cyc(20); bus.btn_step = 1'b0; cyc(20);
    chk("held_then_press", bus.step_cnt, 1);

    // reset in RUN with an auto step pending
    bus.btn_run = 1'b1; cyc(20); bus.btn_run = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.cpu_step) found = 1'b1;
    end
    chk("run_pulse_seen", found, 1);
    cyc(7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cpu_step", bus.cpu_step, 0);
    chk("arst_run_mode", bus.run_mode, 0);
    chk("arst_halted",   bus.halted,   0);
    chk("arst_step_cnt", bus.step_cnt, 0);
    chk("arst_tick",     bus.sample_tick, 0);
    @(negedge clk);
    chk("arst_dropped", bus.cpu_step, 0);
    rst_n = 1'b1;
    cyc(10);

    // randomized button / halt activity against the model
    for (int s = 0; s < 90; s++) begin
      bus.btn_step = ($urandom_range(0, 2) == 0);
      bus.btn_run  = ($urandom_range(0, 3) == 0);
      bus.halt_req = ($urandom_range(0, 7) == 0);
      cyc($urandom_range(1, 24));
    end
    bus.btn_step = 1'b0;
    bus.btn_run  = 1'b0;
    bus.halt_req = 1'b0;
    cyc(30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
